// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store engine. Each load or store from the pipeline becomes one
// byte-lane-enabled request on a word-wide data-RAM port with a req/ack
// handshake. The pipeline is stalled until the access completes. Load data is
// lane-aligned and sign/zero-extended before it reaches the writeback mux.
//
// Build option:
//   ACCESS_TIMEOUT_EN - when defined, a watchdog ends any request that goes
//                       TIMEOUT_CYCLES request cycles without an ack. The
//                       access then finishes with addr_err and no load_valid.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   memRd, memWt  load / store request from the MEM stage
//   Load          000 lb, 001 lbu, 010 lh, 011 lhu, others lw
//   Store         00 sb, 01 sh, others sw
//   addr, wdata   byte address and store data
//   stall         freezes PC/IF/ID/EX/MEM while an access is in flight
//   load_data     aligned, extended load result (held until next load)
//   load_valid    one-cycle pulse when load_data is updated
//   addr_err      one-cycle pulse: misaligned / conflicting / timed-out access
//   mem_req .. mem_wdata   RAM request side, held stable until mem_ack
//   mem_ack, mem_rdata     RAM completion and read word
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRd,
    input  logic              memWt,
    input  logic [2:0]        Load,
    input  logic [1:0]        Store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              addr_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              is_load_q;
    logic [2:0]        ld_type_q;
    logic [1:0]        lane_q;
    logic              mem_we_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       load_data_q;

    logic misalign;
    logic accept;
    logic reject;
    logic timeout_hit;
    logic timed_out;

    // Store byte enables, little-endian lane numbering.
    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lane);
        case (st)
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across the word so any enabled lane sees it.
    function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
        case (st)
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extend_load(input logic [2:0] ld, input logic [1:0] lane,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (ld)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {24'h000000, b};
            3'b010:  extend_load = {{16{h[15]}}, h};
            3'b011:  extend_load = {16'h0000, h};
            default: extend_load = rd;
        endcase
    endfunction

    // Alignment is judged against the op that would be accepted; when both
    // request lines are high the access is rejected regardless.
    always_comb begin
        misalign = 1'b0;
        if (memRd) begin
            case (Load)
                3'b000, 3'b001: misalign = 1'b0;
                3'b010, 3'b011: misalign = addr[0];
                default:        misalign = |addr[1:0];
            endcase
        end else if (memWt) begin
            case (Store)
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = addr[0];
                default: misalign = |addr[1:0];
            endcase
        end
    end

    assign accept = (memRd ^ memWt) & ~misalign;
    assign reject = (memRd | memWt) & ~accept;

`ifdef ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] to_cnt_q;
    logic             timed_out_q;

    assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timed_out   = timed_out_q;

    // timed_out_q is only ever high in the DONE cycle that a timeout produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timed_out_q <= (state_q == S_REQ) && !mem_ack && timeout_hit;
            if (state_q == S_IDLE && accept) begin
                to_cnt_q <= '0;
            end else if (state_q == S_REQ && !mem_ack) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
    assign timed_out             = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ:  if (mem_ack || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. IDLE outputs are masked during reset so a request line
    // held high through reset cannot raise stall or addr_err.
    always_comb begin
        stall      = 1'b0;
        mem_req    = 1'b0;
        load_valid = 1'b0;
        addr_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall    = accept & ~rst;
                addr_err = reject & ~rst;
            end
            S_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            S_DONE: begin
                load_valid = is_load_q & ~timed_out;
                addr_err   = timed_out;
            end
            default: ;
        endcase
    end

    // Request latch and load-result register
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q   <= 1'b0;
            ld_type_q   <= 3'b000;
            lane_q      <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            if (state_q == S_IDLE && accept) begin
                is_load_q   <= memRd;
                ld_type_q   <= Load;
                lane_q      <= addr[1:0];
                mem_we_q    <= memWt;
                mem_addr_q  <= addr[ADDR_W-1:2];
                mem_be_q    <= memRd ? 4'b1111 : store_be(Store, addr[1:0]);
                mem_wdata_q <= store_data(Store, wdata);
            end
            if (state_q == S_REQ && mem_ack && is_load_q) begin
                load_data_q <= extend_load(ld_type_q, lane_q, mem_rdata);
            end
        end
    end

    assign load_data = load_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the control unit's memRd/memWt/Load/Store codes; the memory-side end of that interface.
- Turns each load/store into a byte-lane-enabled request on a word-wide, variable-latency data-RAM port with req/ack handshake.
- Stalls the pipeline until the access completes; aligns and extends load data for the writeback mux.

Parameters:
ADDR_W, 32, byte-address width; mem_addr is word address ADDR_W-2 bits
TIMEOUT_CYCLES, 64, watchdog limit (used only with optional feature)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- memRd  in  1  load request from MEM stage
- memWt  in  1  store request from MEM stage
- Load  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw; 101-111 treated as lw
- Store  in  2  00 sb, 01 sh, 10 sw; 11 treated as sw
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rt)
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- load_data  out  32  aligned, extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- addr_err  out  1  one-cycle pulse, misaligned or illegal access
- mem_req  out  1  request to RAM, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W-2  word address
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  RAM completion, sampled while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset values: state IDLE; stall, load_valid, addr_err, mem_req, mem_we = 0; load_data, mem_addr, mem_be, mem_wdata = 0.
- Reset mid-access: next edge forces IDLE; mem_req drops; pending access is discarded; no load_valid.
- FSM IDLE -> REQ -> DONE -> IDLE.
- IDLE:
  - Legal memRd xor memWt: stall=1 combinationally this cycle; latch op, lane, mem_addr=addr[ADDR_W-1:2], mem_be, mem_wdata; go REQ.
  - memRd and memWt both 1: addr_err=1 for that cycle, no stall, no request, stay IDLE.
- Misalignment (checked in IDLE, no memory request, stall=0, addr_err=1 one cycle):
  - lh/lhu/sh with addr[0]=1
  - lw/sw with addr[1:0]!=0
- REQ:
  - mem_req=1, stall=1; mem_addr/mem_be/mem_wdata/mem_we held stable until ack.
  - mem_ack=1: capture mem_rdata, go DONE. Zero-wait RAM acks in the first REQ cycle.
- DONE:
  - stall=0 so the pipeline advances at this edge; mem_req=0.
  - For loads, load_valid=1 and load_data is registered; load_data holds until the next load completes.
  - Return to IDLE.
- Minimum access is 3 cycles (IDLE-accept, REQ, DONE) with stall high for 2 cycles. Each extra wait state adds one stall cycle.
- Store lanes:
  - sb: be = 1<<addr[1:0], wdata[7:0] replicated ×4
  - sh: addr[1]=0 -> 0011, else 1100; wdata[15:0] replicated ×2
  - sw: 1111, wdata unchanged
- Load lanes: loads drive mem_be=1111. The byte is rdata[8*addr[1:0]+:8], the half is rdata[16*addr[1]+:16]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- mem_ack while mem_req=0 is ignored.
- memRd/memWt changing while stalled is ignored; the latched op is used.

Optional Feature:
- Macro ACCESS_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES:
  - mem_req drops
  - addr_err pulses 1 cycle
  - FSM goes DONE with load_valid=0 and load_data unchanged
- Not defined: no counter; REQ waits for ack indefinitely.

Test Plan:
1. lw addr=0x100, RAM acks in first REQ cycle with 0xDEADBEEF -> mem_be=1111, mem_addr=0x40, stall high 2 cycles, load_valid and load_data=0xDEADBEEF in DONE.
2. lb addr=0x103 and lbu addr=0x103, rdata=0x80FF7F01 -> load_data=0xFFFFFF80 and 0x00000080.
3. sh addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD stable across waits, stall high 5 cycles.
4. lw addr=0x102 and sh addr=0x201 -> addr_err pulse, mem_req never asserts, stall=0; memRd=memWt=1 -> addr_err, no request.
5. rst asserted in REQ with no ack -> next cycle state IDLE, mem_req=0, stall=0, no load_valid.
6. ACCESS_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never given -> mem_req drops after 4 REQ cycles, addr_err pulse, pipeline resumes; without the macro, stall stays high.
